// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser, with
// DATA/STATUS/DIV/CTRL registers. Define MMIO_UART_TX_IRQ_EN to add the o_irq output.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [15:0] CLKDIV_DEFAULT = 16'd867
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_width,
  input  logic        i_we,
  output logic [31:0] o_rdata,
  output logic        o_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [15:0]   div_reg;
  logic          tx_en_reg;
  logic [1:0]    state_reg;
  logic [15:0]   frame_div_reg;
  logic [15:0]   bit_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic [31:0]   rdata_reg;
  logic [31:0]   rd_val;
  logic          irq_bit;
  logic          irq_en_bit;

  logic [1:0] reg_sel;
  logic       wr, push_req, push_ok, pop, empty, full, busy, bit_end, frame_done;

  // Width qualifiers, byte-lane address bits and the upper write data are not needed.
  logic unused_bits;
  assign unused_bits = ^{i_width, i_addr[1:0], i_wdata[31:16]};

  assign reg_sel    = i_addr[3:2];
  assign wr         = i_sel && i_we;
  assign push_req   = wr && (reg_sel == 2'd0);
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == DEPTH_CNT);
  assign busy       = !empty || (state_reg != ST_IDLE);
  assign bit_end    = (bit_cnt_reg == 16'd0);
  assign frame_done = (state_reg == ST_STOP) && bit_end;
  // Popping straight out of the last stop cycle keeps back-to-back frames gapless.
  assign pop        = tx_en_reg && !empty && ((state_reg == ST_IDLE) || frame_done);
  assign push_ok    = push_req && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      div_reg      <= CLKDIV_DEFAULT;
      tx_en_reg    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (wr && (reg_sel == 2'd1) && i_wdata[3])
        overflow_reg <= 1'b0;
      else if (push_req && !push_ok)
        overflow_reg <= 1'b1;
      if (wr && (reg_sel == 2'd2)) div_reg   <= i_wdata[15:0];
      if (wr && (reg_sel == 2'd3)) tx_en_reg <= i_wdata[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      frame_div_reg <= '0;
      bit_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            shift_reg     <= mem[rd_ptr_reg];
            frame_div_reg <= div_reg;
            bit_cnt_reg   <= div_reg;
            state_reg     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            bit_cnt_reg <= frame_div_reg;
            bit_idx_reg <= 3'd0;
            state_reg   <= ST_DATA;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt_reg <= frame_div_reg;
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_reg <= ST_STOP;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 16'd1;
          end
        end
        default: begin
          if (bit_end) begin
            if (pop) begin
              shift_reg     <= mem[rd_ptr_reg];
              frame_div_reg <= div_reg;
              bit_cnt_reg   <= div_reg;
              state_reg     <= ST_START;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 16'd1;
          end
        end
      endcase
    end
  end

  // Line level trails the state by one clock so the output is a clean flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        ST_START: tx_reg <= 1'b0;
        ST_DATA:  tx_reg <= shift_reg[0];
        default:  tx_reg <= 1'b1;
      endcase
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr && (reg_sel == 2'd3)) irq_en_reg <= i_wdata[1];
      irq_reg <= irq_en_reg && empty && (state_reg == ST_IDLE);
    end
  end

  assign irq_bit    = irq_reg;
  assign irq_en_bit = irq_en_reg;
  assign o_irq      = irq_reg;
`else
  assign irq_bit    = 1'b0;
  assign irq_en_bit = 1'b0;
`endif

  always_comb begin
    rd_val = 32'd0;
    unique case (reg_sel)
      2'd1:    rd_val = {27'd0, irq_bit, overflow_reg, empty, full, busy};
      2'd2:    rd_val = {16'd0, div_reg};
      2'd3:    rd_val = {30'd0, irq_en_bit, tx_en_reg};
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdata_reg <= 32'd0;
    else          rdata_reg <= (i_sel && !i_we) ? rd_val : 32'd0;
  end

  assign o_rdata = rdata_reg;
  assign o_tx    = tx_reg;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the CPU data bus (addr/wdata/width/we/rdata) behind the memory controller's address decode.
- Accepts bytes from software into a TX FIFO and serialises them as 8N1 UART frames on o_tx.
- Read data is registered and returned one cycle after the request, matching the CPU's writeback-stage load timing.
- Status, divisor and control registers are exposed for polled or interrupt-driven firmware.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..256.
- CLKDIV_DEFAULT, 16'd867, reset value of DIV (clocks per bit minus 1).

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sel  input  1  access strobe from the controller's address decode; qualifies i_we and read capture.
- i_addr  input  4  byte offset within block; only [3:2] used.
- i_wdata  input  32  write data.
- i_width  input  2  access width (0 byte, 1 half, 2 word); writes of any width are accepted and use low bits.
- i_we  input  1  write enable.
- o_rdata  output  32  registered read data, valid the cycle after i_sel.
- o_tx  output  1  UART serial out, idle high.

Behaviour:
- Register map (i_addr[3:2]):
  - 0 DATA: write pushes i_wdata[7:0]; reads 0.
  - 1 STATUS (read): bit0 busy (FIFO non-empty or frame in flight), bit1 full, bit2 empty, bit3 overflow (sticky), bits[31:4] 0. Writing 1 to bit3 clears overflow; other bits are read-only.
  - 2 DIV: [15:0] R/W, upper bits read 0.
  - 3 CTRL: bit0 tx_en (reset 1), bit1 irq_en (reset 0, see feature).
- Reads:
  - o_rdata <= selected register when i_sel && !i_we; otherwise o_rdata <= 0.
  - Reads are side-effect free.
  - Full word is always returned; width/sign extraction is done by the memory controller.
- Writes: take effect at the clock edge where i_sel && i_we.
- Reset values: o_rdata 0, o_tx 1, FIFO empty, overflow 0, DIV CLKDIV_DEFAULT, CTRL 32'h1, FSM IDLE.
- FIFO:
  - Push to a full FIFO drops the byte and sets overflow.
  - Push and pop in the same cycle when full: pop is evaluated first, the push is accepted, and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH; the count register is one bit wider than the pointers.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if tx_en and FIFO not empty, pop into the shift register, latch the DIV value into the bit counter, go to START. o_tx=1.
  - START: o_tx=0 for DIV+1 cycles.
  - DATA: 8 bits LSB first, each held DIV+1 cycles.
  - STOP: o_tx=1 for DIV+1 cycles, then IDLE. Back-to-back frames therefore have no extra idle cycles.
  - o_tx is registered.
- Latency: a write to DATA at edge N with the FIFO empty and FSM IDLE gives a pop at edge N+1 and o_tx low from edge N+2.
- DIV changes take effect only at the next frame start. DIV=0 is legal and gives a 1-cycle bit.
- Clearing tx_en mid-frame completes the current frame, then holds in IDLE; the FIFO is retained.
- Async reset mid-frame: o_tx returns to 1 immediately and all queued data is discarded.

Optional Feature:
- Macro: MMIO_UART_TX_IRQ_EN.
- Defined:
  - Adds port o_irq (output, 1), registered, reset 0.
  - o_irq = irq_en && FIFO empty && FSM IDLE, updated each cycle.
  - STATUS bit4 mirrors o_irq.
- Undefined:
  - No o_irq port.
  - CTRL bit1 reads 0 and writes to it are ignored.
  - STATUS bit4 reads 0.

Test Plan:
- Reset release, then read STATUS, DIV, CTRL -> o_rdata a cycle later = 32'h4, 32'd867, 32'h1; o_tx=1 throughout.
- DIV=3, write DATA=8'hA5 -> o_tx low at edge N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; STATUS bit0 = 1 during the frame and 0 after.
- DIV=0, tx_en=0, write FIFO_DEPTH+1 bytes -> STATUS full=1 and overflow=1; write 8 to STATUS -> overflow=0. Set tx_en=1 -> exactly FIFO_DEPTH frames emitted with the first 8 bytes in order.
- DIV=0, FIFO full and a frame popping on the same edge as a DATA write -> byte accepted, overflow stays 0, FIFO_DEPTH+1 total frames emitted.
- DIV=9, write 8'h00, then DIV=1 during START -> current frame keeps 10-cycle bits; a following 8'hFF frame uses 2-cycle bits.
- Assert i_rst_n low mid-DATA bit with 3 bytes queued -> o_tx=1 asynchronously, STATUS after release = 32'h4, no further frames. With MMIO_UART_TX_IRQ_EN defined, set irq_en and send one byte -> o_irq=1 only after the stop bit completes.
